// File: rtl/sv_uart_pkg.sv
// Shared UART types: byte width, byte type and packer FSM states.
// Used by the UART engine, its TX/RX paths and the RX word packer.
package sv_uart_pkg;

    localparam int UART_WORD_WIDTH = 8;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic {
        PK_COLLECT,
        PK_FULL
    } packer_state_t;

endpackage

// File: rtl/sv_uart_timeout_cnt.sv
// 16-bit inter-byte timer: clears on iclr or while idle, expires at ilimit-1.
// Ports: iclk, irst, iclr (byte accepted), ien (partial word held), ilimit (0 = off), oexpire.
// Only built with SV_UART_RX_PACKER_TIMEOUT_EN; the packer has no timer otherwise.
`ifdef SV_UART_RX_PACKER_TIMEOUT_EN
module sv_uart_timeout_cnt (
    input  logic        iclk,
    input  logic        irst,
    input  logic        iclr,
    input  logic        ien,
    input  logic [15:0] ilimit,
    output logic        oexpire
);

    logic [15:0] cnt;

    // An accepted byte in the expiry cycle wins, so iclr masks expiry.
    assign oexpire = ien && !iclr && (ilimit != 16'd0) &&
                     (cnt == ilimit - 16'd1);

    always_ff @(posedge iclk) begin
        if (irst || iclr || oexpire || !ien) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/sv_uart_rx_packer.sv
// Packs received UART bytes (MSB byte first) into DATA_WIDTH words on an AXIS master.
// Ports: iclk, irst, s_axis_* (bytes in), m_axis_* (words out), itimeout/otimeout, obyte_cnt.
// Macro SV_UART_RX_PACKER_TIMEOUT_EN enables discarding stalled partial words after itimeout cycles.
module sv_uart_rx_packer
    import sv_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                              iclk,
    input  logic                              irst,
    input  logic [7:0]                        s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic [15:0]                       itimeout,
    output logic                              otimeout,
    output logic [$clog2(DATA_WIDTH/8)-1:0]   obyte_cnt
);

    localparam int N  = DATA_WIDTH / UART_WORD_WIDTH;
    localparam int CW = $clog2(N);

    packer_state_t         state;
    logic [DATA_WIDTH-9:0] shreg;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  accept;
    logic                  last;
    logic                  hs;
    logic                  expire;

    // Partial bytes keep flowing while a word is held; only the byte that
    // would complete the next word must wait for the holding register.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready ||
                           (obyte_cnt != CW'(N - 1));

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign last      = accept && (obyte_cnt == CW'(N - 1));
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign next_word = {shreg, uart_byte_t'(s_axis_tdata)};

`ifdef SV_UART_RX_PACKER_TIMEOUT_EN
    sv_uart_timeout_cnt u_timeout (
        .iclk    (iclk),
        .irst    (irst),
        .iclr    (accept),
        .ien     (obyte_cnt != '0),
        .ilimit  (itimeout),
        .oexpire (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^itimeout;
    assign expire         = 1'b0;
`endif

    always_ff @(posedge iclk) begin
        if (irst) begin
            state         <= PK_COLLECT;
            shreg         <= '0;
            obyte_cnt     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            otimeout      <= 1'b0;
        end else begin
            otimeout <= 1'b0;
            if (accept) begin
                shreg     <= next_word[DATA_WIDTH-9:0];
                obyte_cnt <= last ? '0 : obyte_cnt + CW'(1);
            end else if (expire) begin
                shreg     <= '0;
                obyte_cnt <= '0;
                otimeout  <= 1'b1;
            end
            unique case (state)
                PK_COLLECT: begin
                    if (last) begin
                        m_axis_tdata  <= next_word;
                        m_axis_tvalid <= 1'b1;
                        state         <= PK_FULL;
                    end
                end
                PK_FULL: begin
                    // A completing byte in FULL implies the handshake, so
                    // the new word replaces the old one with no gap.
                    if (last) begin
                        m_axis_tdata <= next_word;
                    end else if (hs) begin
                        m_axis_tvalid <= 1'b0;
                        state         <= PK_COLLECT;
                    end
                end
                default: state <= PK_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sv_uart_rx_packer.sv
// Directed bench for sv_uart_rx_packer (DATA_WIDTH=24).
// Table-driven byte stream plus hand sequences for timeout and mid-word reset.
module tb_sv_uart_rx_packer;

    logic        iclk = 1'b0;
    logic        irst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] itimeout;
    logic        otimeout;
    logic [1:0]  obyte_cnt;

    int checks = 0;
    int errors = 0;

    always #5 iclk = ~iclk;

    sv_uart_rx_packer #(.DATA_WIDTH(24)) dut (
        .iclk          (iclk),
        .irst          (irst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .itimeout      (itimeout),
        .otimeout      (otimeout),
        .obyte_cnt     (obyte_cnt)
    );

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        mrdy;
        logic        e_srdy;
        logic        e_tvalid;
        logic [23:0] e_tdata;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic v, logic [7:0] d, logic r,
                                logic sr, logic tv, logic [23:0] td,
                                logic [1:0] c);
        vec_t x;
        x.vld = v; x.data = d; x.mrdy = r;
        x.e_srdy = sr; x.e_tvalid = tv; x.e_tdata = td; x.e_cnt = c;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        irst          = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        itimeout      = 16'd0;

        vt[0]  = mk(1, 8'hA1, 1, 1, 0, 24'h000000, 2'd1);
        vt[1]  = mk(1, 8'hB2, 1, 1, 0, 24'h000000, 2'd2);
        vt[2]  = mk(1, 8'hC3, 1, 1, 1, 24'hA1B2C3, 2'd0);
        vt[3]  = mk(0, 8'h00, 1, 1, 0, 24'hA1B2C3, 2'd0);
        vt[4]  = mk(1, 8'h01, 0, 1, 0, 24'hA1B2C3, 2'd1);
        vt[5]  = mk(1, 8'h02, 0, 1, 0, 24'hA1B2C3, 2'd2);
        vt[6]  = mk(1, 8'h03, 0, 1, 1, 24'h010203, 2'd0);
        vt[7]  = mk(1, 8'h04, 0, 1, 1, 24'h010203, 2'd1);
        vt[8]  = mk(1, 8'h05, 0, 1, 1, 24'h010203, 2'd2);
        vt[9]  = mk(1, 8'h06, 0, 0, 1, 24'h010203, 2'd2);
        vt[10] = mk(1, 8'h06, 0, 0, 1, 24'h010203, 2'd2);
        vt[11] = mk(1, 8'h06, 1, 1, 1, 24'h040506, 2'd0);
        vt[12] = mk(0, 8'h00, 1, 1, 0, 24'h040506, 2'd0);
        vt[13] = mk(1, 8'h07, 1, 1, 0, 24'h040506, 2'd1);
        vt[14] = mk(1, 8'h08, 1, 1, 0, 24'h040506, 2'd2);
        vt[15] = mk(1, 8'h09, 1, 1, 1, 24'h070809, 2'd0);
        vt[16] = mk(1, 8'h0A, 1, 1, 0, 24'h070809, 2'd1);

        repeat (3) tick();
        irst = 1'b0;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_cnt", 32'(obyte_cnt), 32'd0);
        chk("rst_tmo", 32'(otimeout), 32'd0);
        chk("rst_srdy", 32'(s_axis_tready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            s_axis_tvalid = vt[i].vld;
            s_axis_tdata  = vt[i].data;
            m_axis_tready = vt[i].mrdy;
            @(negedge iclk);
            chk($sformatf("v%0d_srdy", i), 32'(s_axis_tready),
                32'(vt[i].e_srdy));
            tick();
            chk($sformatf("v%0d_tvalid", i), 32'(m_axis_tvalid),
                32'(vt[i].e_tvalid));
            chk($sformatf("v%0d_tdata", i), 32'(m_axis_tdata),
                32'(vt[i].e_tdata));
            chk($sformatf("v%0d_cnt", i), 32'(obyte_cnt),
                32'(vt[i].e_cnt));
        end
        s_axis_tvalid = 1'b0;

        // Flush the partial 0x0A so the timeout run starts clean.
        irst = 1'b1;
        tick();
        irst = 1'b0;

        // Stalled partial word.
        itimeout = 16'd100;
        send(8'h11);
        send(8'h22);
        begin
            int early;
            early = 0;
            for (int i = 0; i < 99; i++) begin
                tick();
                if (otimeout) early++;
            end
            chk("tmo_early", 32'(early), 32'd0);
        end
        tick();
`ifdef SV_UART_RX_PACKER_TIMEOUT_EN
        chk("tmo_pulse", 32'(otimeout), 32'd1);
        chk("tmo_cnt", 32'(obyte_cnt), 32'd0);
        tick();
        chk("tmo_one", 32'(otimeout), 32'd0);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        chk("tmo_word_v", 32'(m_axis_tvalid), 32'd1);
        chk("tmo_word", 32'(m_axis_tdata), 32'h334455);
`else
        chk("tmo_off", 32'(otimeout), 32'd0);
        chk("tmo_keep", 32'(obyte_cnt), 32'd2);
        send(8'h33);
        chk("tmo_word_v", 32'(m_axis_tvalid), 32'd1);
        chk("tmo_word", 32'(m_axis_tdata), 32'h112233);
`endif
        tick();

        // Reset drops both a held word and a partial word.
        itimeout      = 16'd0;
        m_axis_tready = 1'b0;
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'h66);
        send(8'h77);
        chk("mid_pre_cnt", 32'(obyte_cnt), 32'd2);
        chk("mid_pre_v", 32'(m_axis_tvalid), 32'd1);
        irst = 1'b1;
        tick();
        irst = 1'b0;
        chk("mid_cnt", 32'(obyte_cnt), 32'd0);
        chk("mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_tdata", 32'(m_axis_tdata), 32'd0);
        chk("mid_tmo", 32'(otimeout), 32'd0);
        m_axis_tready = 1'b1;
        send(8'h12);
        send(8'h34);
        send(8'h56);
        chk("mid_word_v", 32'(m_axis_tvalid), 32'd1);
        chk("mid_word", 32'(m_axis_tdata), 32'h123456);
        send(8'h78);
        begin
            int hits;
            hits = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (otimeout) hits++;
            end
            chk("tmo_zero_off", 32'(hits), 32'd0);
            chk("tmo_zero_cnt", 32'(obyte_cnt), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
